// File: rtl/pwm_timer_pkg.sv
// Shared constants and types for the PWM/timer peripheral.
package pwm_timer_pkg;

    // CSR byte addresses
    localparam logic [7:0] ADDR_CTRL      = 8'h00;
    localparam logic [7:0] ADDR_CH_EN     = 8'h04;
    localparam logic [7:0] ADDR_PERIOD    = 8'h08;
    localparam logic [7:0] ADDR_POL       = 8'h0C;
    localparam logic [7:0] ADDR_DUTY_BASE = 8'h10;
    localparam logic [7:0] ADDR_CAP_BASE  = 8'h30;
    localparam logic [7:0] ADDR_STATUS    = 8'h50;
    localparam logic [7:0] ADDR_IRQ_EN    = 8'h54;

    // CTRL bit positions
    localparam int CTRL_RUN_BIT      = 0;
    localparam int CTRL_CENTER_BIT   = 1;
    localparam int CTRL_PRESCALE_LSB = 8;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_timer_channel.sv
// One PWM/capture channel: shadowed duty, compare/polarity output,
// synchronized rising-edge capture of the shared timebase.
module pwm_timer_channel #(
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     duty_we_i,
    input  logic [COUNTER_WIDTH-1:0] wdata_i,
    input  logic                     load_i,
    input  logic                     ch_en_i,
    input  logic                     pol_i,
    input  logic [COUNTER_WIDTH-1:0] counter_i,
    input  logic                     capture_i,
    output logic [COUNTER_WIDTH-1:0] duty_sh_o,
    output logic [COUNTER_WIDTH-1:0] capture_o,
    output logic                     cap_event_o,
    output logic                     pwm_o
);

    logic [COUNTER_WIDTH-1:0] duty_sh_q, duty_sh_d;
    logic [COUNTER_WIDTH-1:0] duty_act_q, duty_act_d;
    logic [COUNTER_WIDTH-1:0] cap_q, cap_d;
    logic                     sync1_q, sync2_q, prev_q;
    logic                     pwm_q, pwm_d;
    logic                     cap_event;

    assign cap_event   = sync2_q & ~prev_q;
    assign duty_sh_o   = duty_sh_q;
    assign capture_o   = cap_q;
    assign cap_event_o = cap_event;
    assign pwm_o       = pwm_q;

    // Next-state: a write coinciding with a load goes straight to the active duty.
    always_comb begin
        duty_sh_d  = duty_we_i ? wdata_i : duty_sh_q;
        duty_act_d = load_i ? duty_sh_d : duty_act_q;
        cap_d      = cap_event ? counter_i : cap_q;
        pwm_d      = ch_en_i ? ((counter_i < duty_act_q) ^ pol_i) : pol_i;
    end

    // Channel registers, including the 2-flop synchronizer and edge history.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            duty_sh_q  <= '0;
            duty_act_q <= '0;
            cap_q      <= '0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            pwm_q      <= 1'b0;
        end else begin
            duty_sh_q  <= duty_sh_d;
            duty_act_q <= duty_act_d;
            cap_q      <= cap_d;
            sync1_q    <= capture_i;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            pwm_q      <= pwm_d;
        end
    end

endmodule

// File: rtl/pwm_timer.sv
// Multi-channel PWM/timer: CSR decode, prescaler, up/up-down timebase,
// shadowed period, status flags and interrupt.
//
// dir      | meaning
// DIR_UP   | counter incrementing (edge mode is always up)
// DIR_DOWN | center mode, counting back toward 0 (boundary on reaching 0)
module pwm_timer #(
    parameter int NUM_CHANNELS   = 4,
    parameter int COUNTER_WIDTH  = 16,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [7:0]              csr_addr_i,
    input  logic                    csr_we_i,
    input  logic [31:0]             csr_wdata_i,
    output logic [31:0]             csr_rdata_o,
    output logic [NUM_CHANNELS-1:0] pwm_o,
    output logic [NUM_CHANNELS-1:0] pwm_oe_o,
    input  logic [NUM_CHANNELS-1:0] capture_i,
    output logic                    irq_o
);
    import pwm_timer_pkg::*;

    localparam int N  = NUM_CHANNELS;
    localparam int CW = COUNTER_WIDTH;
    localparam int PW = PRESCALE_WIDTH;

    logic          run_q, run_d, center_q, center_d;
    logic [PW-1:0] prescale_q, prescale_d, presc_cnt_q, presc_cnt_d;
    logic [N-1:0]  ch_en_q, ch_en_d, pol_q, pol_d;
    logic [CW-1:0] period_sh_q, period_sh_d, period_act_q, period_act_d;
    logic [CW-1:0] cnt_q, cnt_d;
    dir_e          dir_q, dir_d;
    logic [N:0]    status_q, status_d, irq_en_q, irq_en_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          tick, boundary, shadow_load;
    logic          wr_ctrl, wr_ch_en, wr_period, wr_pol, wr_status, wr_irq_en;
    logic [N-1:0]  duty_we, cap_event;
    logic [CW-1:0] duty_sh [N];
    logic [CW-1:0] cap_val [N];
    logic          unused_wdata;

    assign wr_ctrl     = csr_we_i && (csr_addr_i == ADDR_CTRL);
    assign wr_ch_en    = csr_we_i && (csr_addr_i == ADDR_CH_EN);
    assign wr_period   = csr_we_i && (csr_addr_i == ADDR_PERIOD);
    assign wr_pol      = csr_we_i && (csr_addr_i == ADDR_POL);
    assign wr_status   = csr_we_i && (csr_addr_i == ADDR_STATUS);
    assign wr_irq_en   = csr_we_i && (csr_addr_i == ADDR_IRQ_EN);
    assign shadow_load = boundary || !run_q;
    assign unused_wdata = ^csr_wdata_i;

    assign csr_rdata_o = rdata_q;
    assign pwm_oe_o    = ch_en_q;
    assign irq_o       = |(status_q & irq_en_q);

    for (genvar g = 0; g < N; g++) begin : g_ch
        assign duty_we[g] = csr_we_i && (csr_addr_i == ADDR_DUTY_BASE + 8'(4 * g));
        pwm_timer_channel #(.COUNTER_WIDTH(CW)) u_ch (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .duty_we_i   (duty_we[g]),
            .wdata_i     (csr_wdata_i[CW-1:0]),
            .load_i      (shadow_load),
            .ch_en_i     (ch_en_q[g]),
            .pol_i       (pol_q[g]),
            .counter_i   (cnt_q),
            .capture_i   (capture_i[g]),
            .duty_sh_o   (duty_sh[g]),
            .capture_o   (cap_val[g]),
            .cap_event_o (cap_event[g]),
            .pwm_o       (pwm_o[g])
        );
    end

    // Prescaler and counter/direction next state; a shrunken PRESCALE still ticks.
    always_comb begin
        presc_cnt_d = presc_cnt_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        boundary    = 1'b0;
        tick        = run_q && (presc_cnt_q >= prescale_q);
        if (run_q) begin
            presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
        end
        if (tick) begin
            if (!center_q) begin
                dir_d = DIR_UP;
                if (cnt_q >= period_act_q) begin
                    cnt_d    = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (period_act_q == '0) begin
                cnt_d    = '0;
                dir_d    = DIR_UP;
                boundary = 1'b1;
            end else if (dir_q == DIR_UP && cnt_q < period_act_q) begin
                cnt_d = cnt_q + 1'b1;
            end else if (cnt_q <= CW'(1)) begin
                cnt_d    = '0;
                dir_d    = DIR_UP;
                boundary = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
                dir_d = DIR_DOWN;
            end
        end
    end

    // CSR register writes, period shadowing and status set-over-clear.
    always_comb begin
        run_d        = wr_ctrl ? csr_wdata_i[CTRL_RUN_BIT] : run_q;
        center_d     = wr_ctrl ? csr_wdata_i[CTRL_CENTER_BIT] : center_q;
        prescale_d   = wr_ctrl ? csr_wdata_i[CTRL_PRESCALE_LSB +: PW] : prescale_q;
        ch_en_d      = wr_ch_en ? csr_wdata_i[N-1:0] : ch_en_q;
        pol_d        = wr_pol ? csr_wdata_i[N-1:0] : pol_q;
        irq_en_d     = wr_irq_en ? csr_wdata_i[N:0] : irq_en_q;
        period_sh_d  = wr_period ? csr_wdata_i[CW-1:0] : period_sh_q;
        period_act_d = shadow_load ? period_sh_d : period_act_q;
        status_d     = wr_status ? (status_q & ~csr_wdata_i[N:0]) : status_q;
        status_d     = status_d | {boundary, cap_event};
    end

    // Read mux, registered into csr_rdata_o.
    always_comb begin
        rdata_d = '0;
        unique case (csr_addr_i)
            ADDR_CTRL: begin
                rdata_d[CTRL_RUN_BIT]                = run_q;
                rdata_d[CTRL_CENTER_BIT]             = center_q;
                rdata_d[CTRL_PRESCALE_LSB +: PW]     = prescale_q;
            end
            ADDR_CH_EN:  rdata_d = 32'(ch_en_q);
            ADDR_PERIOD: rdata_d = 32'(period_sh_q);
            ADDR_POL:    rdata_d = 32'(pol_q);
            ADDR_STATUS: rdata_d = 32'(status_q);
            ADDR_IRQ_EN: rdata_d = 32'(irq_en_q);
            default: begin
                for (int i = 0; i < N; i++) begin
                    if (csr_addr_i == ADDR_DUTY_BASE + 8'(4 * i)) rdata_d = 32'(duty_sh[i]);
                    if (csr_addr_i == ADDR_CAP_BASE + 8'(4 * i))  rdata_d = 32'(cap_val[i]);
                end
            end
        endcase
    end

    // Top-level state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q        <= 1'b0;
            center_q     <= 1'b0;
            prescale_q   <= '0;
            presc_cnt_q  <= '0;
            ch_en_q      <= '0;
            pol_q        <= '0;
            period_sh_q  <= '0;
            period_act_q <= '0;
            cnt_q        <= '0;
            dir_q        <= DIR_UP;
            status_q     <= '0;
            irq_en_q     <= '0;
            rdata_q      <= '0;
        end else begin
            run_q        <= run_d;
            center_q     <= center_d;
            prescale_q   <= prescale_d;
            presc_cnt_q  <= presc_cnt_d;
            ch_en_q      <= ch_en_d;
            pol_q        <= pol_d;
            period_sh_q  <= period_sh_d;
            period_act_q <= period_act_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            status_q     <= status_d;
            irq_en_q     <= irq_en_d;
            rdata_q      <= rdata_d;
        end
    end

endmodule

// File: tb/tb_pwm_timer.sv
// Scoreboarded bench for pwm_timer with default parameters (4 ch, 16-bit).
module tb_pwm_timer;
    import pwm_timer_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [7:0]  csr_addr_i;
    logic        csr_we_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_rdata_o;
    logic [3:0]  pwm_o, pwm_oe_o, capture_i;
    logic        irq_o;

    int    n_tests = 0;
    int    n_fail  = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    localparam int PH_DUTY [6] = '{0, 10, 10, 0, 0, 0};
    localparam int PH_POL  [6] = '{0, 0, 1, 1, 1, 0};
    localparam int PH_EN   [6] = '{1, 1, 1, 1, 0, 0};
    localparam int PH_PWM  [6] = '{0, 1, 0, 1, 1, 0};

    pwm_timer dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .csr_addr_i  (csr_addr_i),
        .csr_we_i    (csr_we_i),
        .csr_wdata_i (csr_wdata_i),
        .csr_rdata_o (csr_rdata_o),
        .pwm_o       (pwm_o),
        .pwm_oe_o    (pwm_oe_o),
        .capture_i   (capture_i),
        .irq_o       (irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference timebase: counter value after a given number of ticks from 0.
    function automatic int model_cnt(input bit center, input int period, input int ticks);
        int p;
        if (period == 0) return 0;
        if (!center) return ticks % (period + 1);
        p = ticks % (2 * period);
        return (p <= period) ? p : 2 * period - p;
    endfunction

    task automatic do_reset();
        csr_we_i = 1'b0; csr_addr_i = '0; csr_wdata_i = '0; capture_i = '0;
        @(negedge clk_i); rst_ni = 1'b0;
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic csr_write(input logic [7:0] a, input logic [31:0] d);
        csr_addr_i = a; csr_wdata_i = d; csr_we_i = 1'b1;
        @(posedge clk_i); #1;
        csr_we_i = 1'b0;
    endtask

    task automatic csr_read(input logic [7:0] a, output logic [31:0] d);
        csr_addr_i = a;
        @(posedge clk_i); #1;
        d = csr_rdata_o;
    endtask

    task automatic test_reset();
        logic [31:0] e, obs[4];
        string nm;
        csr_we_i = 1'b0; csr_addr_i = '0; csr_wdata_i = '0; capture_i = '0;
        rst_ni = 1'b0;
        name_q.push_back("por_pwm");   exp_q.push_back(32'h0);
        name_q.push_back("por_oe");    exp_q.push_back(32'h0);
        name_q.push_back("por_irq");   exp_q.push_back(32'h0);
        name_q.push_back("por_rdata"); exp_q.push_back(32'h0);
        #12;
        obs[0] = 32'(pwm_o); obs[1] = 32'(pwm_oe_o); obs[2] = 32'(irq_o); obs[3] = csr_rdata_o;
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front(); nm = name_q.pop_front(); n_tests++;
            if (obs[i] !== e) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", nm, obs[i], e); end
        end
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_edge();
        logic [31:0] e, obs;
        string nm;
        int hi;
        do_reset();
        csr_write(ADDR_PERIOD, 32'd9);
        csr_write(ADDR_DUTY_BASE, 32'd3);
        csr_write(ADDR_CH_EN, 32'd1);
        csr_write(ADDR_CTRL, 32'h1);
        for (int k = 1; k <= 30; k++) begin
            name_q.push_back($sformatf("edge_pwm0_k%0d", k));
            exp_q.push_back(32'(model_cnt(1'b0, 9, k - 1) < 3));
        end
        hi = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk_i); #1;
            obs = 32'(pwm_o[0]);
            if (k > 10 && k <= 20) hi += int'(pwm_o[0]);
            e = exp_q.pop_front(); nm = name_q.pop_front(); n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL %s: got %0d expected %0d", nm, obs, e); end
        end
        n_tests++;
        if (hi != 3) begin n_fail++; $display("FAIL edge_high_count: got %0d expected 3", hi); end
        name_q.push_back("edge_oe"); exp_q.push_back(32'h1);
        obs = 32'(pwm_oe_o);
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", nm, obs, e); end
    endtask

    task automatic test_center();
        logic [31:0] e, obs;
        string nm;
        int len;
        for (int p = 0; p < 2; p++) begin
            do_reset();
            csr_write(ADDR_PERIOD, 32'd4);
            csr_write(ADDR_DUTY_BASE, 32'd2);
            csr_write(ADDR_CH_EN, 32'd1);
            csr_write(ADDR_CTRL, 32'h3 | (32'(p) << 8));
            len = 16 * (p + 1) + 2;
            for (int k = 1; k <= len; k++) begin
                name_q.push_back($sformatf("center_p%0d_k%0d", p, k));
                exp_q.push_back(32'(model_cnt(1'b1, 4, (k - 1) / (p + 1)) < 2));
            end
            for (int k = 1; k <= len; k++) begin
                @(posedge clk_i); #1;
                obs = 32'(pwm_o[0]);
                e = exp_q.pop_front(); nm = name_q.pop_front(); n_tests++;
                if (obs !== e) begin n_fail++; $display("FAIL %s: got %0d expected %0d", nm, obs, e); end
            end
        end
    endtask

    task automatic test_shadow();
        logic [31:0] e, obs;
        string nm;
        int duty;
        do_reset();
        csr_write(ADDR_PERIOD, 32'd9);
        csr_write(ADDR_DUTY_BASE, 32'd3);
        csr_write(ADDR_CH_EN, 32'd1);
        csr_write(ADDR_CTRL, 32'h1);
        for (int k = 1; k <= 35; k++) begin
            duty = (k - 1 < 10) ? 3 : (k - 1 < 20) ? 7 : 5;
            name_q.push_back($sformatf("shadow_pwm0_k%0d", k));
            exp_q.push_back(32'(model_cnt(1'b0, 9, k - 1) < duty));
        end
        for (int k = 1; k <= 35; k++) begin
            if (k == 5 || k == 20) begin
                csr_addr_i = ADDR_DUTY_BASE;
                csr_wdata_i = (k == 5) ? 32'd7 : 32'd5;
                csr_we_i = 1'b1;
            end
            @(posedge clk_i); #1;
            csr_we_i = 1'b0;
            obs = 32'(pwm_o[0]);
            e = exp_q.pop_front(); nm = name_q.pop_front(); n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL %s: got %0d expected %0d", nm, obs, e); end
        end
    endtask

    task automatic test_capture();
        logic [31:0] e, obs;
        string nm;
        do_reset();
        csr_write(ADDR_IRQ_EN, 32'h02);
        csr_write(ADDR_PERIOD, 32'd9);
        csr_write(ADDR_CTRL, 32'h1);
        repeat (6) @(posedge clk_i);
        #1;
        csr_write(ADDR_CTRL, 32'h0);
        name_q.push_back("cap_irq_2cyc");  exp_q.push_back(32'h0);
        name_q.push_back("cap_irq_3cyc");  exp_q.push_back(32'h1);
        name_q.push_back("cap1_value");    exp_q.push_back(32'd7);
        name_q.push_back("cap_status");    exp_q.push_back(32'h02);
        name_q.push_back("cap_irq_clr");   exp_q.push_back(32'h0);
        name_q.push_back("cap_status_clr"); exp_q.push_back(32'h0);
        name_q.push_back("cap_setwins_status"); exp_q.push_back(32'h02);
        name_q.push_back("cap_setwins_irq");    exp_q.push_back(32'h1);
        capture_i[1] = 1'b1;
        repeat (2) @(posedge clk_i);
        #1; obs = 32'(irq_o);
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL %s: got %0d expected %0d", nm, obs, e); end
        @(posedge clk_i); #1; obs = 32'(irq_o);
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL %s: got %0d expected %0d", nm, obs, e); end
        csr_read(ADDR_CAP_BASE + 8'd4, obs);
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", nm, obs, e); end
        csr_read(ADDR_STATUS, obs);
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", nm, obs, e); end
        csr_write(ADDR_STATUS, 32'h02);
        obs = 32'(irq_o);
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL %s: got %0d expected %0d", nm, obs, e); end
        csr_read(ADDR_STATUS, obs);
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", nm, obs, e); end
        // new edge detected on the same edge as the W1C clear
        capture_i[1] = 1'b0;
        repeat (4) @(posedge clk_i);
        #1; capture_i[1] = 1'b1;
        repeat (2) @(posedge clk_i);
        #1; csr_write(ADDR_STATUS, 32'h02);
        csr_read(ADDR_STATUS, obs);
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", nm, obs, e); end
        obs = 32'(irq_o);
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL %s: got %0d expected %0d", nm, obs, e); end
        capture_i = '0;
    endtask

    task automatic test_bounds();
        logic [31:0] e, obs;
        string nm;
        do_reset();
        csr_write(ADDR_PERIOD, 32'd9);
        csr_write(ADDR_CTRL, 32'h1);
        for (int ph = 0; ph < 6; ph++) begin
            csr_write(ADDR_DUTY_BASE, 32'(PH_DUTY[ph]));
            csr_write(ADDR_POL, 32'(PH_POL[ph]));
            csr_write(ADDR_CH_EN, 32'(PH_EN[ph]));
            repeat (12) @(posedge clk_i);
            #1;
            name_q.push_back($sformatf("bound_ph%0d_oe", ph)); exp_q.push_back(32'(PH_EN[ph]));
            for (int k = 0; k < 10; k++) begin
                name_q.push_back($sformatf("bound_ph%0d_pwm_k%0d", ph, k));
                exp_q.push_back(32'(PH_PWM[ph]));
            end
            obs = 32'(pwm_oe_o);
            e = exp_q.pop_front(); nm = name_q.pop_front(); n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", nm, obs, e); end
            for (int k = 0; k < 10; k++) begin
                @(posedge clk_i); #1;
                obs = 32'(pwm_o);
                e = exp_q.pop_front(); nm = name_q.pop_front(); n_tests++;
                if (obs !== e) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", nm, obs, e); end
            end
        end
        // PERIOD=0: every tick is a boundary, so a clear of the period flag loses
        csr_write(ADDR_IRQ_EN, 32'h10);
        csr_write(ADDR_PERIOD, 32'd0);
        repeat (12) @(posedge clk_i);
        #1;
        name_q.push_back("p0_status"); exp_q.push_back(32'h10);
        name_q.push_back("p0_irq");    exp_q.push_back(32'h1);
        csr_write(ADDR_STATUS, 32'h10);
        csr_read(ADDR_STATUS, obs);
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", nm, obs, e); end
        obs = 32'(irq_o);
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL %s: got %0d expected %0d", nm, obs, e); end
    endtask

    task automatic test_reset_midperiod();
        logic [31:0] e, obs;
        logic [31:0] obs_v[4];
        logic [7:0]  addrs[17];
        string nm;
        do_reset();
        csr_write(ADDR_PERIOD, 32'd9);
        csr_write(ADDR_DUTY_BASE, 32'd10);
        csr_write(ADDR_CH_EN, 32'd1);
        csr_write(ADDR_IRQ_EN, 32'h10);
        csr_write(ADDR_CTRL, 32'h1);
        repeat (12) @(posedge clk_i);
        #1;
        csr_addr_i = ADDR_CH_EN;
        @(posedge clk_i);
        #3;
        name_q.push_back("rst_pwm");   exp_q.push_back(32'h0);
        name_q.push_back("rst_oe");    exp_q.push_back(32'h0);
        name_q.push_back("rst_irq");   exp_q.push_back(32'h0);
        name_q.push_back("rst_rdata"); exp_q.push_back(32'h0);
        rst_ni = 1'b0;
        #1;
        obs_v[0] = 32'(pwm_o); obs_v[1] = 32'(pwm_oe_o); obs_v[2] = 32'(irq_o); obs_v[3] = csr_rdata_o;
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front(); nm = name_q.pop_front(); n_tests++;
            if (obs_v[i] !== e) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", nm, obs_v[i], e); end
        end
        #10; rst_ni = 1'b1;
        @(posedge clk_i); #1;
        csr_write(8'h58, 32'hFFFF_FFFF);
        addrs = '{ADDR_CTRL, ADDR_CH_EN, ADDR_PERIOD, ADDR_POL,
                  8'h10, 8'h14, 8'h18, 8'h1C, 8'h30, 8'h34, 8'h38, 8'h3C,
                  ADDR_STATUS, ADDR_IRQ_EN, 8'h58, 8'h5C, 8'h40};
        for (int i = 0; i < 17; i++) begin
            name_q.push_back($sformatf("rst_readback_0x%02h", addrs[i]));
            exp_q.push_back(32'h0);
        end
        for (int i = 0; i < 17; i++) begin
            csr_read(addrs[i], obs);
            e = exp_q.pop_front(); nm = name_q.pop_front(); n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL %s: got 0x%0h expected 0x%0h", nm, obs, e); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_edge();
        test_center();
        test_shadow();
        test_capture();
        test_bounds();
        test_reset_midperiod();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_timer.md
# pwm_timer

Parametrised multi-channel PWM/timer peripheral on the CSR bus. It generalises the first-generation PWM block in four ways: programmable period, edge- or center-aligned counting, per-channel output polarity, and glitch-free shadowed duty/period updates. Input capture now sets status flags and drives a maskable interrupt. It sits between the CSR fabric and the pad ring; GPIO lives in a separate block.

## Interface
- NUM_CHANNELS, 4, PWM/capture channel count, legal 1..8
- COUNTER_WIDTH, 16, timebase counter, PERIOD, DUTY and CAPTURE width, legal 2..32
- PRESCALE_WIDTH, 8, prescaler width, legal 1..8
- clk_i  in  1  single clock
- rst_ni  in  1  reset, asynchronous, active-low
- csr_addr_i  in  8  byte address, word-aligned
- csr_we_i  in  1  write strobe, one cycle per write
- csr_wdata_i  in  32  write data
- csr_rdata_o  out  32  read data, registered
- pwm_o  out  NUM_CHANNELS  PWM outputs
- pwm_oe_o  out  NUM_CHANNELS  pad output enables, equal to CH_EN
- capture_i  in  NUM_CHANNELS  asynchronous capture inputs
- irq_o  out  1  level interrupt

## Operation
- Register map. All fields reset to 0. Unmapped reads return 0 and unmapped writes are ignored.
  - 0x00 CTRL: [0] RUN, [1] CENTER, [8+:PRESCALE_WIDTH] PRESCALE.
  - 0x04 CH_EN [N-1:0].
  - 0x08 PERIOD (shadowed).
  - 0x0C POL [N-1:0].
  - 0x10+4·ch DUTY (shadowed).
  - 0x30+4·ch CAPTURE, read-only.
  - 0x50 STATUS: [N-1:0] capture flags, [N] period flag, write-1-to-clear.
  - 0x54 IRQ_EN [N:0].
- Prescaler: while RUN=1, presc_cnt counts 0..PRESCALE and produces a tick when presc_cnt==PRESCALE. The counter advances only on a tick. When RUN=0, presc_cnt and the counter hold their values.
- Edge mode (CENTER=0): the counter counts 0..PERIOD_act, then wraps to 0. The boundary is the tick on which the counter wraps.
- Center mode (CENTER=1): the counter counts up to PERIOD_act, then down to 0, then reverses. Period is 2·PERIOD_act ticks. The boundary is the tick on which the counter reaches 0.
- PERIOD_act=0: the counter stays at 0 and every tick is a boundary.
- Compare: raw = (counter < DUTY_act[ch]). pwm_o[ch] = CH_EN[ch] ? raw ^ POL[ch] : POL[ch].
  - DUTY=0 gives a constant inactive level.
  - DUTY > PERIOD gives a constant active level.
- Shadowing: PERIOD and DUTY writes go to shadow registers.
  - Active registers load from shadow on each boundary.
  - When RUN=0, active registers load from shadow every cycle.
  - If a write lands in the same cycle as a boundary, the written value is loaded directly into the active register.
- Capture: each capture_i bit passes through a 2-flop synchronizer and then a rising-edge detector. On a detected edge, CAPTURE[ch] ← counter and STATUS[ch] ← 1. Capture works whether RUN is 0 or 1.
- STATUS[N] is set on every boundary.
- If a W1C clear and a set hit the same bit in the same cycle, the set wins.
- irq_o = |(STATUS & IRQ_EN), computed combinationally from registers.

## Timing
- Writes take effect on the clock edge where csr_we_i=1.
  - CTRL, CH_EN and POL affect pwm_o and pwm_oe_o on the next cycle.
  - DUTY and PERIOD affect outputs after the next boundary.
- Reads: csr_rdata_o is registered, valid the cycle after the address is presented, and holds until the address changes.
- pwm_o is a registered compare output: it reflects the counter value of the previous cycle.
- Capture latency: 3 cycles from a capture_i rise to the CAPTURE/STATUS update. irq_o follows the STATUS update with no added delay.
- Reset, asynchronous on rst_ni low, at any time including mid-period or mid-capture:
  - pwm_o, pwm_oe_o, irq_o and csr_rdata_o go to 0.
  - Counter goes to 0 with direction up.
  - Synchronizers clear.
  - Operation restarts on the first edge after deassertion.

## Structure
- Package pwm_timer_pkg holds:
  - address constants (CTRL, CH_EN, PERIOD, POL, DUTY_BASE, CAP_BASE, STATUS, IRQ_EN);
  - CTRL bit positions;
  - the count-direction enum (DIR_UP, DIR_DOWN).
- Sub-module pwm_timer_channel, instantiated per channel, contains:
  - shadow and active duty registers;
  - compare and polarity logic;
  - capture synchronizer, edge detector and capture register.
- The top level holds the CSR decode, prescaler, counter/direction FSM and status/IRQ logic.

## Test plan
- Edge mode with PRESCALE=0, PERIOD=9, DUTY0=3, CH_EN=1, RUN=1: pwm_o[0] is high for 3 of every 10 cycles and pwm_oe_o=4'b0001.
- Center mode with PERIOD=4, DUTY0=2: 8-cycle period, pwm_o[0] high for 3 cycles (counter values 1,0,1); with PRESCALE=1 the period becomes 16 cycles.
- Shadow update with PERIOD=9: writing DUTY0 3→7 mid-period leaves the current period at 3 high cycles; the next period has 7 high cycles with no runt pulse. A write on the boundary cycle applies immediately.
- Capture on channel 1 with IRQ_EN=0x02: raising capture_i[1] makes CAPTURE1 equal the counter value 3 cycles later, with STATUS[1]=1 and irq_o=1. Writing 0x02 to STATUS clears both. A clear in the same cycle as a new edge leaves the flag set.
- Boundaries, PERIOD=9:
  - DUTY=0 gives constant 0.
  - DUTY=10 gives constant 1.
  - POL=1 inverts both.
  - Clearing CH_EN gives pwm_oe_o=0 and pwm_o=POL.
  - PERIOD=0 gives STATUS[N] set every tick.
- Reset: assert rst_ni mid-period between clock edges; all outputs go to 0 immediately. After release, readback of every register is 0.
